// File: rtl/pdm_frontend_mc.sv
// PDM microphone front end, one or two interleaved channels.
// Divides clk down to mic_clk and captures ch0 at the end of each mic_clk high phase and ch1 at
// the end of each low phase. Each channel runs through a CIC_N-stage CIC decimator (ratio
// 2^DECIM_LOG2) whose output is scaled and saturated to OUT_W bits. Samples go into a
// channel-tagged FIFO.
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   en                 run enable; low stops mic_clk and clears the filters
//   pdm_data           asynchronous PDM bit stream from the mic(s)
//   mic_clk            clock to the mic(s)
//   out_data/out_ch    sample and channel at the FIFO head (zero when empty)
//   out_valid          FIFO non-empty
//   out_ready          pop the head when out_valid && out_ready
//   overflow, ovf_clr  sticky drop-on-full flag and its clear
//   fifo_level         FIFO occupancy
module pdm_frontend_mc #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned CIC_N      = 4,
    parameter int unsigned DECIM_LOG2 = 4,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          pdm_data,
    output logic                          mic_clk,
    output logic [OUT_W-1:0]              out_data,
    output logic                          out_ch,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int unsigned W     = CIC_N * DECIM_LOG2 + 2;
    localparam int unsigned SHIFT = CIC_N * DECIM_LOG2 - (OUT_W - 1);
    localparam int unsigned CW    = $clog2(CLK_DIV);
    localparam int unsigned WUW   = $clog2(CIC_N + 1);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam logic signed [W-1:0] SAT_MAX = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {{(W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [CW-1:0]         div_cnt_q, div_cnt_d;
    logic                  mic_clk_q, mic_clk_d;
    logic                  high_seen_q, high_seen_d;
    logic                  sync1_q, sync2_q;
    logic                  div_end;
    logic [NUM_CH-1:0]     cap, strobe;
    logic [W-1:0]          integ_q [NUM_CH][CIC_N];
    logic [W-1:0]          integ_d [NUM_CH][CIC_N];
    logic [W-1:0]          dly_q   [NUM_CH][CIC_N];
    logic [W-1:0]          dly_d   [NUM_CH][CIC_N];
    logic [DECIM_LOG2-1:0] ph_q    [NUM_CH];
    logic [DECIM_LOG2-1:0] ph_d    [NUM_CH];
    logic [WUW-1:0]        warm_q  [NUM_CH];
    logic [WUW-1:0]        warm_d  [NUM_CH];
    logic                  comb_go_q, comb_go_d, comb_ch_q, comb_ch_d;
    logic signed [W-1:0]   comb_res, scaled;
    logic                  push_req;
    logic [OUT_W-1:0]      push_data;
    logic [OUT_W:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]           fifo_cnt_q, fifo_cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  full, pop, push_ok;

    // Divider and capture strobes.
    always_comb begin
        div_end   = en && (div_cnt_q == CW'(CLK_DIV - 1));
        div_cnt_d = div_cnt_q + CW'(1);
        mic_clk_d = mic_clk_q;
        if (!en) begin
            div_cnt_d = '0;
            mic_clk_d = 1'b0;
        end else if (div_end) begin
            div_cnt_d = '0;
            mic_clk_d = ~mic_clk_q;
        end
        // ch1 waits for the first ch0 capture so ch0 leads in every decimation period.
        for (int c = 0; c < NUM_CH; c++) begin
            cap[c] = div_end && ((c == 0) ? mic_clk_q : (!mic_clk_q && high_seen_q));
        end
        high_seen_d = en && (high_seen_q || cap[0]);
    end

    // CIC integrators on capture, comb chain one cycle after the strobe.
    always_comb begin : cic_comb
        logic [W-1:0] x_val, acc, c_in;
        x_val    = sync2_q ? W'(1) : '1;
        acc      = '0;
        c_in     = '0;
        integ_d  = integ_q;
        dly_d    = dly_q;
        ph_d     = ph_q;
        warm_d   = warm_q;
        strobe   = '0;
        comb_res = '0;
        push_req = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cap[c]) begin
                acc = x_val;
                for (int i = 0; i < CIC_N; i++) begin
                    integ_d[c][i] = integ_q[c][i] + acc;
                    acc           = integ_d[c][i];
                end
                ph_d[c]   = ph_q[c] + DECIM_LOG2'(1);
                strobe[c] = (ph_q[c] == '1);
            end
            if (comb_go_q && (comb_ch_q == 1'(c))) begin
                c_in = integ_q[c][CIC_N-1];
                for (int i = 0; i < CIC_N; i++) begin
                    dly_d[c][i] = c_in;
                    c_in        = c_in - dly_q[c][i];
                end
                comb_res = signed'(c_in);
                if (warm_q[c] == WUW'(CIC_N)) begin
                    push_req = en;
                end else begin
                    warm_d[c] = warm_q[c] + WUW'(1);
                end
            end
        end
        comb_go_d = |strobe;
        comb_ch_d = (NUM_CH > 1) ? strobe[NUM_CH-1] : 1'b0;
        if (!en) begin
            integ_d   = '{default: '0};
            dly_d     = '{default: '0};
            ph_d      = '{default: '0};
            warm_d    = '{default: '0};
            comb_go_d = 1'b0;
            comb_ch_d = 1'b0;
        end
        scaled = comb_res >>> SHIFT;
        if (scaled > SAT_MAX) begin
            push_data = SAT_MAX[OUT_W-1:0];
        end else if (scaled < SAT_MIN) begin
            push_data = SAT_MIN[OUT_W-1:0];
        end else begin
            push_data = scaled[OUT_W-1:0];
        end
    end

    // Output FIFO.
    always_comb begin
        full       = (fifo_cnt_q == (AW+1)'(FIFO_DEPTH));
        out_valid  = (fifo_cnt_q != '0);
        pop        = out_valid && out_ready;
        push_ok    = push_req && (!full || pop);
        wr_ptr_d   = wr_ptr_q + AW'(push_ok);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        fifo_cnt_d = fifo_cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
        // A new drop wins over a simultaneous clear.
        ovf_d      = (ovf_q && !ovf_clr) || (push_req && full && !pop);
        out_data   = out_valid ? mem_q[rd_ptr_q][OUT_W-1:0] : '0;
        out_ch     = out_valid ? mem_q[rd_ptr_q][OUT_W] : 1'b0;
        mic_clk    = mic_clk_q;
        overflow   = ovf_q;
        fifo_level = fifo_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {comb_ch_q, push_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q   <= '0;
            mic_clk_q   <= 1'b0;
            high_seen_q <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            integ_q     <= '{default: '0};
            dly_q       <= '{default: '0};
            ph_q        <= '{default: '0};
            warm_q      <= '{default: '0};
            comb_go_q   <= 1'b0;
            comb_ch_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            mic_clk_q   <= mic_clk_d;
            high_seen_q <= high_seen_d;
            sync1_q     <= pdm_data;
            sync2_q     <= sync1_q;
            integ_q     <= integ_d;
            dly_q       <= dly_d;
            ph_q        <= ph_d;
            warm_q      <= warm_d;
            comb_go_q   <= comb_go_d;
            comb_ch_q   <= comb_ch_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            ovf_q       <= ovf_d;
        end
    end
endmodule

// File: doc/pdm_frontend_mc.md
Name: pdm_frontend_mc

Overview:
Parametrised successor to the single-channel mic front end. It generates the PDM mic clock from the system clock and captures one or two interleaved PDM channels on opposite mic-clock phases. Each channel runs through an N-stage CIC decimator with a power-of-two ratio. Decimated PCM is pushed through a channel-tagged FIFO with a valid/ready output, which feeds the downstream halfband/FIR or SPI stage.

Parameters:
CLK_DIV, 4, system clk cycles per mic_clk half-period (>=2)
NUM_CH, 2, channels (1 or 2); ch0 on mic_clk high phase, ch1 on low phase
CIC_N, 4, CIC stages (1..5)
DECIM_LOG2, 4, log2 of decimation ratio R; CIC_N*DECIM_LOG2 >= OUT_W-1
OUT_W, 16, output sample width (signed)
FIFO_DEPTH, 8, output FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  run enable
pdm_data  in  1  PDM data from mic(s), asynchronous
mic_clk  out  1  clock to mic(s)
out_data  out  OUT_W  signed PCM sample at FIFO head
out_ch  out  1  channel of out_data (0/1)
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head when out_valid&&out_ready
overflow  out  1  sticky: sample dropped on full FIFO
ovf_clr  in  1  clears overflow
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: mic_clk=0, out_valid=0, out_data=0, out_ch=0, overflow=0, fifo_level=0. Reset also clears the divider, CIC state, warm-up counters and FIFO pointers.
- Reset mid-operation: all of the above clear on the next clk edge. In-flight samples are discarded.
- Clock gen: while en=1, a counter toggles mic_clk every CLK_DIV clk cycles.
- en=0: mic_clk is forced low, counter is held at 0, and all CIC state and warm-up counters are cleared. FIFO contents remain readable.
- en rising: first mic_clk rise occurs CLK_DIV cycles later.
- Sync: pdm_data passes through a 2-flop synchroniser.
- Capture: ch0 takes the synced bit on the last clk cycle of each mic_clk high phase. ch1 (NUM_CH=2 only) takes it on the last cycle of each low phase.
- Bit mapping: 1 -> +1, 0 -> -1.
- CIC per channel:
  - Internal width W = CIC_N*DECIM_LOG2+2, two's complement with wrap-around (modular) arithmetic.
  - Integrators update once per channel capture.
  - Decimation strobe fires every R=2^DECIM_LOG2 captures of ch0. The ch1 strobe is its own R-th capture.
  - The comb chain (differential delay 1) runs on each strobe.
- Scaling: y = comb_out >>> (CIC_N*DECIM_LOG2-(OUT_W-1)). Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; the positive limit is hit by all-ones input.
- Warm-up: after reset or en rising, the first CIC_N decimated outputs per channel are discarded and not written to the FIFO.
- Latency: a channel's sample is written to the FIFO 1 clk after its strobe cycle. If the FIFO was empty, out_valid rises the following cycle.
- Handshake:
  - out_data and out_ch are stable while out_valid=1 && out_ready=0.
  - A pop happens exactly on cycles where out_valid&&out_ready.
- Full: a write to a full FIFO with no pop that cycle drops the new sample and sets overflow. Existing entries are untouched.
- Full with simultaneous push and pop: both succeed and the level is unchanged.
- Empty with simultaneous push and pop: no pop (out_valid=0). The push lands and out_valid=1 the next cycle.
- overflow: stays set until ovf_clr=1 or reset. If ovf_clr and a new overflow occur in the same cycle, overflow ends set.
- Ordering: samples pop in write order. Per decimation period the ch0 sample precedes the ch1 sample. Pointers wrap modulo FIFO_DEPTH.

Test Plan:
1. Reset then en=1, defaults, pdm_data held 1, out_ready=1.
   - mic_clk period is 8 clk.
   - First CIC_N=4 outputs per channel are suppressed.
   - Subsequent samples are out_data=32767, alternating out_ch 0,1.
2. pdm_data held 0 -> steady-state out_data=-32768 on both channels.
3. ch0 bits all 1 and ch1 bits all 0 (pdm_data driven in phase with mic_clk).
   - ch0 samples = 32767 and ch1 samples = -32768.
   - This proves the phase/channel mapping.
4. Steady 1/0 pattern per channel (bit flips each ch0 capture) -> settled out_data=0.
5. out_ready=0 for 20 decimation periods.
   - fifo_level reaches 8 and overflow=1.
   - Draining gives the 8 oldest samples in order.
   - ovf_clr pulse clears overflow.
6. Disturbance test:
   - Reset asserted mid-stream -> next cycle out_valid=0, fifo_level=0, mic_clk=0.
   - en dropped mid-stream -> mic_clk stops low and queued samples stay poppable.
   - Re-enable -> warm-up discard repeats.
